// File: rtl/foc_pkg.sv
// Shared FOC definitions: default widths, transform FSM states, rounding constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package foc_pkg;

  localparam int D_WIDTH_DEF = 18;  // signed data width
  localparam int Q_BITS_DEF  = 15;  // fractional bits of sin/cos

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4
  } state_t;

  // Half an LSB of the Q-format result: added before the arithmetic shift
  // so the shift rounds half up instead of flooring.
  function automatic longint round_const(input int q_bits);
    return longint'(1) <<< (q_bits - 1);
  endfunction

endpackage

// File: rtl/round_sat.sv
// Round a wide Q-format accumulator to OUT_W bits (half up), then clamp or wrap.
// Latency: combinational.
// Backpressure: none.
// Ports: acc (IN_W signed accumulator, Q_BITS fractional), res (OUT_W signed).
// Build option: INV_PARK_SAT_EN clamps out-of-range results; otherwise wraps.
module round_sat
  import foc_pkg::*;
#(
  parameter int IN_W   = 37,
  parameter int OUT_W  = 18,
  parameter int Q_BITS = 15
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] res
);

  localparam int RW = IN_W + 1;         // one guard bit so the rounding add cannot overflow
  localparam int SW = RW - Q_BITS;      // integer part after the shift
  localparam logic signed [RW-1:0] RND = RW'(round_const(Q_BITS));

  logic signed [RW-1:0] sum;
  logic signed [SW-1:0] rnd;
  logic                 unused_frac;

  assign sum         = {acc[IN_W-1], acc} + RND;
  assign rnd         = sum[RW-1:Q_BITS];  // arithmetic shift right by Q_BITS
  assign unused_frac = ^sum[Q_BITS-1:0];

`ifdef INV_PARK_SAT_EN
  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  // In range exactly when every bit above the output sign matches it.
  logic [SW-OUT_W:0] hi;
  assign hi = rnd[SW-1:OUT_W-1];

  always_comb begin
    res = rnd[OUT_W-1:0];
    if (!((&hi) || !(|hi))) begin
      res = rnd[SW-1] ? MIN_V : MAX_V;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^rnd[SW-1:OUT_W];
  assign res       = rnd[OUT_W-1:0];
`endif

endmodule

// File: rtl/inv_park.sv
// Inverse Park transform: alpha = d*cos - q*sin, beta = d*sin + q*cos, one shared multiplier.
// Latency: 4 cycles from the start-sampling edge to done; one transform per 5 cycles.
// Backpressure: none; start is sampled only in IDLE, starts while busy are dropped.
// Ports: clk, rst (async active-high), d_in/q_in/sin/cos (D_WIDTH signed, sin/cos Q_BITS
//        fractional), start; alpha/beta (D_WIDTH signed, held between done pulses), done, busy.
// Build option: INV_PARK_SAT_EN saturates results, otherwise two's-complement wrap.
module inv_park
  import foc_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int Q_BITS  = Q_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [D_WIDTH-1:0] d_in,
  input  logic signed [D_WIDTH-1:0] q_in,
  input  logic signed [D_WIDTH-1:0] sin,
  input  logic signed [D_WIDTH-1:0] cos,
  input  logic                      start,
  output logic signed [D_WIDTH-1:0] alpha,
  output logic signed [D_WIDTH-1:0] beta,
  output logic                      done,
  output logic                      busy
);

  localparam int PW = 2 * D_WIDTH;      // product width
  localparam int AW = 2 * D_WIDTH + 1;  // accumulator width, holds sum of two products

  state_t state, state_nxt;

  logic signed [D_WIDTH-1:0] d_r, q_r, s_r, c_r;
  logic signed [AW-1:0]      acc_a, acc_b;
  logic signed [D_WIDTH-1:0] mul_x, mul_y;
  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      prod_x;
  logic signed [AW-1:0]      acc_b_sum;
  logic signed [D_WIDTH-1:0] alpha_rnd, beta_rnd;

  // Operand select for the shared multiplier.
  always_comb begin
    mul_x = d_r;
    mul_y = c_r;
    case (state)
      P1:      begin mul_x = q_r; mul_y = s_r; end
      P2:      begin mul_x = d_r; mul_y = s_r; end
      P3:      begin mul_x = q_r; mul_y = c_r; end
      default: begin mul_x = d_r; mul_y = c_r; end
    endcase
  end

  assign prod      = mul_x * mul_y;
  assign prod_x    = {prod[PW-1], prod};
  // beta is finished in the same cycle it is written out, so round the
  // combinational sum rather than the registered accumulator.
  assign acc_b_sum = acc_b + prod_x;

  round_sat #(.IN_W(AW), .OUT_W(D_WIDTH), .Q_BITS(Q_BITS)) u_round_a (
    .acc (acc_a),
    .res (alpha_rnd)
  );

  round_sat #(.IN_W(AW), .OUT_W(D_WIDTH), .Q_BITS(Q_BITS)) u_round_b (
    .acc (acc_b_sum),
    .res (beta_rnd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = P0;
      P0:      state_nxt = P1;
      P1:      state_nxt = P2;
      P2:      state_nxt = P3;
      P3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      d_r   <= '0;
      q_r   <= '0;
      s_r   <= '0;
      c_r   <= '0;
      acc_a <= '0;
      acc_b <= '0;
      alpha <= '0;
      beta  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d_r <= d_in;
            q_r <= q_in;
            s_r <= sin;
            c_r <= cos;
          end
        end
        P0: acc_a <= prod_x;
        P1: acc_a <= acc_a - prod_x;
        P2: acc_b <= prod_x;
        P3: begin
          acc_b <= acc_b_sum;
          alpha <= alpha_rnd;
          beta  <= beta_rnd;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_park.sv
// Directed bench for inv_park at D_WIDTH=18, Q_BITS=15 with hand-computed results.
// Latency: checks done exactly 4 cycles after the capture edge.
// Backpressure: checks start is ignored while busy.
module tb_inv_park;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [17:0] d_in, q_in, sin, cos;
  logic               start;
  logic signed [17:0] alpha, beta;
  logic               done, busy;

  int checks = 0;
  int errors = 0;

  inv_park dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .q_in  (q_in),
    .sin   (sin),
    .cos   (cos),
    .start (start),
    .alpha (alpha),
    .beta  (beta),
    .done  (done),
    .busy  (busy)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int q, input int s, input int c);
    d_in = 18'(d);
    q_in = 18'(q);
    sin  = 18'(s);
    cos  = 18'(c);
  endtask

  task automatic junk();
    d_in = 18'($urandom);
    q_in = 18'($urandom);
    sin  = 18'($urandom);
    cos  = 18'($urandom);
  endtask

  // Single pulsed start; inputs scrambled right after capture.
  task automatic run_one(input string tag, input int d, input int q, input int s, input int c,
                         input int ea, input int eb);
    drive(d, q, s, c);
    start = 1'b1;
    tick();
    start = 1'b0;
    junk();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s busy[%0d]", tag, i), longint'(busy), 1);
      chk($sformatf("%s done_early[%0d]", tag, i), longint'(done), 0);
      tick();
    end
    chk({tag, " done"}, longint'(done), 1);
    chk({tag, " busy_end"}, longint'(busy), 0);
    chk({tag, " alpha"}, longint'(alpha), longint'(ea));
    chk({tag, " beta"}, longint'(beta), longint'(eb));
    tick();
    chk({tag, " done_pulse"}, longint'(done), 0);
    chk({tag, " alpha_hold"}, longint'(alpha), longint'(ea));
  endtask

  // Streaming vectors: d, q, sin, cos, alpha, beta
  typedef struct {
    int d; int q; int s; int c; int ea; int eb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1,     0,    0,     16384, 1,     0};     // +0.5 rounds up
    vecs[1] = '{-1,    0,    0,     16384, 0,     0};     // -0.5 rounds up to 0
    vecs[2] = '{-4096, 8192, 16384, 0,     -4096, -2048};
    vecs[3] = '{3,     5,    16384, 16384, -1,    4};
    vecs[4] = '{1000,  2000, 0,     32767, 1000,  2000};

    rst   = 1'b1;
    start = 1'b0;
    drive(0, 0, 0, 0);
    #2;
    chk("rst alpha", longint'(alpha), 0);
    chk("rst beta", longint'(beta), 0);
    chk("rst done", longint'(done), 0);
    chk("rst busy", longint'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_one("v031", 16384, 0, 0, 32767, 16384, 0);
    run_one("v032", 0, 16384, 32767, 0, -16383, 0);
`ifdef INV_PARK_SAT_EN
    run_one("v033", 131071, -131072, 23170, 23170, 131071, -1);
`else
    run_one("v033", 131071, -131072, 23170, 23170, -76785, -1);
`endif

    // start held high: one capture every 5 cycles, inputs junk in between.
    drive(vecs[0].d, vecs[0].q, vecs[0].s, vecs[0].c);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      junk();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("stream%0d done_early[%0d]", k, i), longint'(done), 0);
        tick();
      end
      chk($sformatf("stream%0d done", k), longint'(done), 1);
      chk($sformatf("stream%0d alpha", k), longint'(alpha), longint'(vecs[k].ea));
      chk($sformatf("stream%0d beta", k), longint'(beta), longint'(vecs[k].eb));
      if (k < 4) drive(vecs[k+1].d, vecs[k+1].q, vecs[k+1].s, vecs[k+1].c);
    end
    start = 1'b0;
    tick();

    // Abort mid-transform with reset.
    drive(16384, 0, 0, 32767);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort alpha", longint'(alpha), 0);
    chk("abort beta", longint'(beta), 0);
    chk("abort busy", longint'(busy), 0);
    chk("abort done", longint'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("post_rst done[%0d]", i), longint'(done), 0);
      chk($sformatf("post_rst busy[%0d]", i), longint'(busy), 0);
      tick();
    end
    run_one("after_rst", 3, 5, 16384, 16384, -1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
